// File: rtl/apu_pkg.sv
// apu_pkg: shared sweep FSM state type and constants for the APU channel-1 sweep
package apu_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, ADD} sweep_state_t;

    localparam logic [10:0] FREQ_MAX          = 11'h7FF;
    localparam logic [3:0]  SWEEP_PERIOD_ZERO = 4'd8;

endpackage

// File: rtl/ch1_sweep_shifter.sv
// ch1_sweep_shifter: operand register that shifts right once per cycle while a shift count runs down
module ch1_sweep_shifter #(
    parameter int W  = 11,
    parameter int CW = 3
) (
    input  logic          dyfa_1mhz,
    input  logic          napu_reset,
    input  logic          load,
    input  logic          shift_en,
    input  logic [W-1:0]  load_val,
    input  logic [CW-1:0] load_cnt,
    output logic [W-1:0]  operand,
    output logic          done
);

    logic [CW-1:0] count;

    // Load operand and count together; each shift halves the operand and consumes one count
    always_ff @(posedge dyfa_1mhz) begin
        if (!napu_reset) begin
            operand <= '0;
            count   <= '0;
        end else if (load) begin
            operand <= load_val;
            count   <= load_cnt;
        end else if (shift_en) begin
            operand <= operand >> 1;
            count   <= count - 1'b1;
        end
    end

    // The shift happening this cycle is the final one
    assign done = (count <= CW'(1));

endmodule

// File: rtl/ch1_sweep.sv
// ch1_sweep: channel-1 frequency sweep with shadow register, serial shift/add and overflow kill
module ch1_sweep
    import apu_pkg::*;
#(
    parameter int FREQ_W   = 11,
    parameter int SHIFT_W  = 3,
    parameter int PERIOD_W = 3
) (
    input  logic                        dyfa_1mhz,
    input  logic                        napu_reset,
    input  logic [PERIOD_W+SHIFT_W:0]   nff10,
    input  logic [7:0]                  d,
    input  logic                        ff13_wr,
    input  logic                        ff14_wr,
    input  logic                        ch1_restart,
    input  logic                        sweep_tick,
    output logic [FREQ_W-1:0]           acc_d,
    output logic                        freq_upd,
    output logic                        ch1_off,
    output logic                        sweep_busy
);

    localparam int TW = PERIOD_W + 1;

    sweep_state_t state, state_nx;

    logic [FREQ_W-1:0]   shadow;
    logic [FREQ_W-1:0]   operand;
    logic [FREQ_W:0]     sum;
    logic [TW-1:0]       timer, timer_dec, reload;
    logic [PERIOD_W-1:0] period;
    logic [SHIFT_W-1:0]  shift;
    logic                negate, neg_q, neg_used, enable, wb;
    logic                sh_done, tick_fire, tick_start, overflow, do_wb, quirk;

    // NR10 fields arrive inverted and are used live
    assign period = ~nff10[PERIOD_W+SHIFT_W:SHIFT_W+1];
    assign negate = ~nff10[SHIFT_W];
    assign shift  = ~nff10[SHIFT_W-1:0];

    assign reload     = (period == '0) ? TW'(SWEEP_PERIOD_ZERO) : TW'(period);
    assign timer_dec  = timer - 1'b1;
    assign tick_fire  = sweep_tick && (timer != '0) && (timer_dec == '0);
    assign tick_start = tick_fire && enable && (period != '0) && (state == IDLE);

    assign sum      = negate ? ({1'b0, shadow} - {1'b0, operand}) : ({1'b0, shadow} + {1'b0, operand});
    assign overflow = sum > {1'b0, FREQ_W'(FREQ_MAX)};
    assign do_wb    = (state == ADD) && !overflow && wb && (shift != '0) && !ch1_restart;
    assign quirk    = neg_used && neg_q && !negate;

    assign sweep_busy = (state != IDLE);

    ch1_sweep_shifter #(.W(FREQ_W), .CW(SHIFT_W)) u_shifter (
        .dyfa_1mhz  (dyfa_1mhz),
        .napu_reset (napu_reset),
        .load       (state == LOAD),
        .shift_en   (state == SHIFT),
        .load_val   (shadow),
        .load_cnt   (shift),
        .operand    (operand),
        .done       (sh_done)
    );

    // Next state: a trigger overrides everything; a writeback pass is followed by one check-only pass
    always_comb begin
        state_nx = state;
        if (ch1_restart)
            state_nx = (shift != '0) ? LOAD : IDLE;
        else if (state == IDLE)
            state_nx = tick_start ? LOAD : IDLE;
        else if (state == LOAD)
            state_nx = (shift != '0) ? SHIFT : ADD;
        else if (state == SHIFT)
            state_nx = sh_done ? ADD : SHIFT;
        else
            state_nx = do_wb ? LOAD : IDLE;
    end

    // Sweep state, frequency register, timer and one-cycle output pulses
    always_ff @(posedge dyfa_1mhz) begin
        if (!napu_reset) begin
            state    <= IDLE;
            acc_d    <= '0;
            shadow   <= '0;
            timer    <= '0;
            enable   <= 1'b0;
            neg_used <= 1'b0;
            neg_q    <= 1'b0;
            wb       <= 1'b0;
            freq_upd <= 1'b0;
            ch1_off  <= 1'b0;
        end else begin
            state    <= state_nx;
            neg_q    <= negate;
            freq_upd <= do_wb;
            ch1_off  <= (!ch1_restart && state == ADD && overflow) || quirk;
            if (do_wb) begin
                acc_d <= sum[FREQ_W-1:0];
            end else begin
                if (ff13_wr) acc_d[7:0] <= d;
                if (ff14_wr) acc_d[FREQ_W-1:8] <= d[FREQ_W-9:0];
            end
            if (ch1_restart) begin
                shadow   <= acc_d;
                timer    <= reload;
                enable   <= (period != '0) || (shift != '0);
                neg_used <= 1'b0;
                wb       <= 1'b0;
            end else begin
                if (sweep_tick && timer != '0) timer <= (timer_dec == '0) ? reload : timer_dec;
                if (tick_start) wb <= 1'b1;
                else if (state == ADD) wb <= 1'b0;
                if (do_wb) shadow <= sum[FREQ_W-1:0];
                if (state == ADD && negate) neg_used <= 1'b1;
                if ((state == ADD && overflow) || quirk) enable <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ch1_sweep.sv
// tb_ch1_sweep: directed vector table plus hand-written sequences for the channel-1 sweep
module tb_ch1_sweep;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  nff10;
    logic [7:0]  d;
    logic        ff13_wr, ff14_wr, restart, tick;
    logic [10:0] acc_d;
    logic        freq_upd, ch1_off, busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ch1_sweep dut (
        .dyfa_1mhz   (clk),
        .napu_reset  (rst_n),
        .nff10       (nff10),
        .d           (d),
        .ff13_wr     (ff13_wr),
        .ff14_wr     (ff14_wr),
        .ch1_restart (restart),
        .sweep_tick  (tick),
        .acc_d       (acc_d),
        .freq_upd    (freq_upd),
        .ch1_off     (ch1_off),
        .sweep_busy  (busy)
    );

    typedef struct {
        logic [10:0] acc;
        logic        neg;
        logic [2:0]  sh;
        logic [10:0] exp_acc;
        logic        exp_fu;
        logic        exp_off;
    } vec_t;

    vec_t vt[8];

    function automatic logic [6:0] nr10(input logic [2:0] p, input logic n, input logic [2:0] s);
        return ~{p, n, s};
    endfunction

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
    endtask

    task automatic set_acc(input logic [10:0] v);
        d = v[7:0];
        ff13_wr = 1'b1;
        cyc();
        ff13_wr = 1'b0;
        d = {5'b0, v[10:8]};
        ff14_wr = 1'b1;
        cyc();
        ff14_wr = 1'b0;
    endtask

    task automatic pulse_restart;
        restart = 1'b1;
        cyc();
        restart = 1'b0;
    endtask

    task automatic pulse_tick;
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while (busy && k < 50) begin
            cyc();
            k++;
        end
        chk(nm, 16'(busy), 16'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int np;
        nff10 = '1; d = '0; ff13_wr = 1'b0; ff14_wr = 1'b0; restart = 1'b0; tick = 1'b0;

        vt[0] = '{11'h100, 1'b0, 3'd1, 11'h180, 1'b1, 1'b0};
        vt[1] = '{11'h400, 1'b1, 3'd2, 11'h300, 1'b1, 1'b0};
        vt[2] = '{11'h123, 1'b0, 3'd3, 11'h147, 1'b1, 1'b0};
        vt[3] = '{11'h7F0, 1'b1, 3'd1, 11'h3F8, 1'b1, 1'b0};
        vt[4] = '{11'h555, 1'b0, 3'd7, 11'h55F, 1'b1, 1'b0};
        vt[5] = '{11'h3FF, 1'b0, 3'd1, 11'h5FE, 1'b1, 1'b0};
        vt[6] = '{11'h200, 1'b0, 3'd0, 11'h200, 1'b0, 1'b0};
        vt[7] = '{11'h500, 1'b0, 3'd0, 11'h500, 1'b0, 1'b1};

        // reset state and CPU writes
        cyc(2);
        chk("rst acc_d", 16'(acc_d), 16'h0);
        chk("rst freq_upd", 16'(freq_upd), 16'h0);
        chk("rst ch1_off", 16'(ch1_off), 16'h0);
        chk("rst busy", 16'(busy), 16'h0);
        rst_n = 1'b1;
        set_acc(11'h100);
        chk("cpu acc_d", 16'(acc_d), 16'h100);
        chk("cpu freq_upd", 16'(freq_upd), 16'h0);
        chk("cpu ch1_off", 16'(ch1_off), 16'h0);

        // single writeback step per vector, sampled at the ADD edge T+2+shift
        foreach (vt[i]) begin
            do_reset;
            nff10 = nr10(3'd1, vt[i].neg, vt[i].sh);
            set_acc(vt[i].acc);
            pulse_restart;
            wait_idle("vec idle");
            pulse_tick;
            cyc(2 + int'(vt[i].sh));
            chk("vec acc_d", 16'(acc_d), 16'(vt[i].exp_acc));
            chk("vec freq_upd", 16'(freq_upd), 16'(vt[i].exp_fu));
            chk("vec ch1_off", 16'(ch1_off), 16'(vt[i].exp_off));
        end

        // two consecutive additive sweeps with exact latency
        do_reset;
        nff10 = nr10(3'd1, 1'b0, 3'd1);
        set_acc(11'h100);
        pulse_restart;
        wait_idle("t2 idle0");
        pulse_tick;
        cyc(2);
        chk("t2 early fu", 16'(freq_upd), 16'h0);
        cyc(1);
        chk("t2 acc1", 16'(acc_d), 16'h180);
        chk("t2 fu1", 16'(freq_upd), 16'h1);
        wait_idle("t2 idle1");
        pulse_tick;
        cyc(3);
        chk("t2 acc2", 16'(acc_d), 16'h240);
        chk("t2 fu2", 16'(freq_upd), 16'h1);

        // negate sweep, then clearing negate kills the channel once
        do_reset;
        nff10 = nr10(3'd1, 1'b1, 3'd2);
        set_acc(11'h400);
        pulse_restart;
        wait_idle("t3 idle0");
        pulse_tick;
        cyc(4);
        chk("t3 acc", 16'(acc_d), 16'h300);
        chk("t3 fu", 16'(freq_upd), 16'h1);
        wait_idle("t3 idle1");
        nff10 = nr10(3'd1, 1'b0, 3'd2);
        cyc();
        chk("t3 quirk off", 16'(ch1_off), 16'h1);
        np = 0;
        repeat (5) begin
            cyc();
            np += int'(ch1_off);
        end
        chk("t3 quirk once", 16'(np), 16'h0);

        // check-only overflow on trigger
        do_reset;
        nff10 = nr10(3'd1, 1'b0, 3'd1);
        set_acc(11'h700);
        pulse_restart;
        cyc(2);
        chk("t4 early off", 16'(ch1_off), 16'h0);
        cyc(1);
        chk("t4 off", 16'(ch1_off), 16'h1);
        chk("t4 acc", 16'(acc_d), 16'h700);
        wait_idle("t4 idle");
        pulse_tick;
        chk("t4 disabled", 16'(busy), 16'h0);

        // period 2, writeback then recheck overflow at T+8
        do_reset;
        nff10 = nr10(3'd2, 1'b0, 3'd2);
        set_acc(11'h600);
        pulse_restart;
        wait_idle("t5 idle");
        pulse_tick;
        chk("t5 first tick", 16'(busy), 16'h0);
        pulse_tick;
        cyc(4);
        chk("t5 acc", 16'(acc_d), 16'h780);
        chk("t5 fu", 16'(freq_upd), 16'h1);
        cyc(3);
        chk("t5 early off", 16'(ch1_off), 16'h0);
        cyc(1);
        chk("t5 off", 16'(ch1_off), 16'h1);

        // restart during SHIFT aborts the writeback
        do_reset;
        nff10 = nr10(3'd1, 1'b0, 3'd3);
        set_acc(11'h100);
        pulse_restart;
        wait_idle("t6 idle0");
        pulse_tick;
        cyc(2);
        pulse_restart;
        np = 0;
        repeat (20) begin
            cyc();
            np += int'(freq_upd);
        end
        chk("t6 abort fu", 16'(np), 16'h0);
        chk("t6 abort acc", 16'(acc_d), 16'h100);

        // reset asserted on the ADD edge
        wait_idle("t6 idle1");
        pulse_tick;
        cyc(4);
        rst_n = 1'b0;
        cyc();
        chk("t6 rst acc", 16'(acc_d), 16'h0);
        chk("t6 rst fu", 16'(freq_upd), 16'h0);
        chk("t6 rst off", 16'(ch1_off), 16'h0);
        chk("t6 rst busy", 16'(busy), 16'h0);
        rst_n = 1'b1;
        np = 0;
        repeat (10) begin
            cyc();
            np += int'(freq_upd) + int'(ch1_off) + int'(busy);
        end
        chk("t6 quiet", 16'(np), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ch1_sweep.md
Name: ch1_sweep

Overview:
Channel-1 frequency sweep unit. It holds the 11-bit NR13/NR14 frequency and its shadow copy. On each sweep step it computes shadow ± (shadow >> shift) serially at 1 MHz and writes the result back. It drives acc_d, which loads channel 1's frequency counter, and kills the channel on overflow.

Parameters:
FREQ_W, 11, frequency/shadow width.
SHIFT_W, 3, NR10 shift-field width.
PERIOD_W, 3, NR10 period-field width.

Ports:
dyfa_1mhz  in  1  APU 1 MHz clock; all state changes on rising edge.
napu_reset  in  1  synchronous, active-low reset.
nff10  in  7  inverted NR10 latch bits [6:0]: period = ~nff10[6:4], negate = ~nff10[3], shift = ~nff10[2:0].
d  in  8  CPU data bus value, sampled on write strobes.
ff13_wr  in  1  one-cycle NR13 write strobe.
ff14_wr  in  1  one-cycle NR14 write strobe.
ch1_restart  in  1  one-cycle trigger pulse.
sweep_tick  in  1  one-cycle 128 Hz frame-sequencer enable.
acc_d  out  11  frequency register value, to the channel-1 counter load.
freq_upd  out  1  one-cycle pulse when the sweep writes acc_d.
ch1_off  out  1  one-cycle pulse requesting channel disable.
sweep_busy  out  1  high while a calculation is in flight.

Behaviour:
- One clock; reset is synchronous and active-low. While napu_reset=0, all of the following are 0: acc_d, shadow, timer, enable flag, negate-used flag, freq_upd, ch1_off, sweep_busy. FSM is in IDLE.
- CPU writes:
  - ff13_wr loads acc_d[7:0] <= d.
  - ff14_wr loads acc_d[10:8] <= d[2:0].
  - Neither write touches shadow.
- Trigger (ch1_restart, at any state):
  - shadow <= acc_d; timer <= period, or 8 if period=0.
  - enable <= (period!=0) or (shift!=0); negate-used <= 0.
  - Any in-flight calculation is aborted.
  - If shift!=0, start a check-only calculation (no writeback).
- Tick: on sweep_tick, timer decrements if nonzero. When it reaches 0:
  - Reload timer (period, or 8 if period=0).
  - If enable=1, period!=0 and FSM is IDLE, start a writeback calculation.
  - A reload event while busy is dropped.
- FSM states: IDLE, LOAD, SHIFT, ADD.
  - IDLE -> LOAD when a calculation starts.
  - LOAD: operand <= shadow, count <= shift.
  - SHIFT: operand >>= 1 each cycle; stays exactly `shift` cycles; skipped when shift=0.
  - ADD: sum = shadow + operand, or shadow − operand if negate=1. Sum is 12 bits; subtraction cannot underflow.
  - If negate=1, set negate-used <= 1.
- ADD results:
  - sum > 0x7FF: pulse ch1_off, enable <= 0, go to IDLE.
  - Else, writeback pass with shift!=0: shadow <= sum[10:0], acc_d <= sum[10:0], pulse freq_upd, then one recheck pass (LOAD..ADD, check-only).
  - Otherwise go to IDLE.
- Latency: tick on cycle T with shift=s gives LOAD at T+1, SHIFT T+2..T+1+s, ADD at T+2+s (acc_d/freq_upd). The recheck ADD is at T+4+2s.
- Negate quirk: if negate-used=1 and negate becomes 0 (nff10[3] rises), pulse ch1_off once and set enable <= 0.
- Same-cycle collisions:
  - Sweep writeback beats a CPU ff13/ff14 write on acc_d.
  - ch1_restart beats sweep_tick.
  - Reset beats everything.
- Period, negate and shift are re-read live from nff10 at LOAD/ADD. No latching beyond the operand.
- sweep_busy = (state != IDLE).

Decomposition:
- apu_pkg: typedef sweep_state_t {IDLE, LOAD, SHIFT, ADD}; constants FREQ_MAX=11'h7FF and SWEEP_PERIOD_ZERO=4'd8.
- One sub-module, ch1_sweep_shifter, holds the operand register plus shift counter: load, shift-enable, done.
- The adder, overflow compare and FSM stay in ch1_sweep.

Test Plan:
1. Reset, then CPU writes ff13=0x00, ff14=0x01 -> acc_d=0x100, no freq_upd/ch1_off.
2. acc_d=0x100, NR10 period=1, shift=1, add; trigger; sweep_tick -> acc_d=0x180 with freq_upd at T+3. Next tick -> 0x240.
3. acc_d=0x400, period=1, shift=2, negate; trigger, tick -> acc_d=0x300. Then clear negate -> single ch1_off pulse.
4. acc_d=0x700, shift=1, period=1; trigger -> check-only calc gives 0xA80 > 0x7FF, so ch1_off at trigger+3 and acc_d stays 0x700.
5. acc_d=0x600, shift=2, period=2: first tick gives no calc. Second tick gives 0x780; recheck 0x960 raises ch1_off at T+8.
6. ch1_restart during SHIFT, and reset asserted mid-ADD: calc aborted, no freq_upd. After reset all outputs are 0 and sweep_busy=0 on the next edge.
